// File: rtl/trajectory_step_sequencer_if.sv
// trajectory_step_sequencer_if: step request/acknowledge handshake between the sequencer and the trajectory datapath
interface trajectory_step_sequencer_if #(parameter int N = 64);
  logic step_req;
  logic step_ack;
  logic [N-1:0] frac_alt;
  logic [N-1:0] frac_dist;
  modport master (output step_req, input step_ack, frac_alt, frac_dist);
  modport slave (input step_req, output step_ack, frac_alt, frac_dist);
endinterface

// File: rtl/trajectory_step_sequencer.sv
// trajectory_step_sequencer: issues one datapath step at a time and accumulates altitude/distance until target, budget or timeout
module trajectory_step_sequencer #(
  parameter int N = 64,
  parameter logic [N-1:0] TARGET_ALT = N'(64'd188000000000000),
  parameter int MAX_STEPS = 4096,
  parameter int STEP_W = 16,
  parameter int ACK_TIMEOUT = 16
) (
  input logic clk,
  input logic resetb,
  input logic start,
  input logic abort,
  input logic [N-1:0] alt_init,
  trajectory_step_sequencer_if.master dp,
  output logic [N-1:0] altitude,
  output logic [N-1:0] distance,
  output logic [STEP_W-1:0] step_count,
  output logic busy,
  output logic done,
  output logic reached,
  output logic err_timeout
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, REQ, CHECK, DONE, ERROR} state_t;
  state_t state;
  logic [TW-1:0] tcnt;
  logic [N:0] alt_sum;
  logic [N:0] dist_sum;
  assign alt_sum = {1'b0, altitude} + {1'b0, dp.frac_alt};
  assign dist_sum = {1'b0, distance} + {1'b0, dp.frac_dist};
  assign dp.step_req = state == REQ;
  assign busy = state == REQ || state == CHECK;
  assign done = state == DONE;
  assign err_timeout = state == ERROR;
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      state <= IDLE;
      tcnt <= '0;
      altitude <= '0;
      distance <= '0;
      step_count <= '0;
      reached <= 1'b0;
    end else
      case (state)
        REQ:
          if (abort) state <= IDLE;
          else if (dp.step_ack) begin
            altitude <= alt_sum[N] ? '1 : alt_sum[N-1:0];
            distance <= dist_sum[N] ? '1 : dist_sum[N-1:0];
            step_count <= step_count + 1'b1;
            state <= CHECK;
          end
          else if (tcnt == TW'(ACK_TIMEOUT - 1)) state <= ERROR;
          else tcnt <= tcnt + 1'b1;
        CHECK:
          if (abort) state <= IDLE;
          else if (altitude >= TARGET_ALT) begin
            reached <= 1'b1;
            state <= DONE;
          end
          else if (step_count == STEP_W'(MAX_STEPS)) state <= DONE;
          else begin
            tcnt <= '0;
            state <= REQ;
          end
        default:
          if (start) begin
            altitude <= alt_init;
            distance <= '0;
            step_count <= '0;
            tcnt <= '0;
            reached <= 1'b0;
            state <= REQ;
          end
      endcase
endmodule
